// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares the SPI configuration-flash pins between the
// bootloader bridge (port 0) and user/debug logic (port 1). Grants are
// round-robin and held for a whole CS-low transaction. Stalled owners are
// revoked. A boot request drains the bus, waits a fixed idle time and then
// fires the sticky warmboot trigger.
module spi_flash_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned BOOT_DELAY     = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic cs0_i,
    input  logic cs1_i,
    input  logic sck0_i,
    input  logic sck1_i,
    input  logic mosi0_i,
    input  logic mosi1_i,
    input  logic boot_req_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic spi_cs_o,
    output logic spi_sck_o,
    output logic spi_mosi_o,
    output logic timeout_err_o,
    output logic boot_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_G0    = 3'd1,
        S_G1    = 3'd2,
        S_REL   = 3'd3,
        S_BWAIT = 3'd4,
        S_BOOT  = 3'd5
    } state_e;

    state_e        state_q;
    logic          last_q;
    logic          boot_pend_q;
    logic          blk0_q, blk1_q;
    logic          sck0_q, sck1_q;
    logic [TW-1:0] tcnt_q;
    logic [DW-1:0] dcnt_q;
    logic          timeout_err_q;
    logic          boot_q;

    // Helper terms for the FSM. A boot request in the same cycle as new
    // requests must already block grants, so the raw input is folded in.
    logic pend, elig0, elig1, sck_chg0, sck_chg1, tmo;
    assign pend     = boot_pend_q | boot_req_i;
    assign elig0    = req0_i & ~blk0_q;
    assign elig1    = req1_i & ~blk1_q;
    assign sck_chg0 = sck0_i ^ sck0_q;
    assign sck_chg1 = sck1_i ^ sck1_q;
    assign tmo      = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Arbitration / stall-watchdog / warmboot sequencing FSM.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            last_q        <= 1'b1;
            boot_pend_q   <= 1'b0;
            blk0_q        <= 1'b0;
            blk1_q        <= 1'b0;
            sck0_q        <= 1'b0;
            sck1_q        <= 1'b0;
            tcnt_q        <= '0;
            dcnt_q        <= '0;
            timeout_err_q <= 1'b0;
            boot_q        <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            sck0_q        <= sck0_i;
            sck1_q        <= sck1_i;
            if (boot_req_i) boot_pend_q <= 1'b1;
            // An offender is only re-eligible after it has dropped req.
            if (!req0_i) blk0_q <= 1'b0;
            if (!req1_i) blk1_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (pend) begin
                        state_q <= S_BWAIT;
                        dcnt_q  <= DW'(BOOT_DELAY - 1);
                    end else if (elig0 && elig1) begin
                        state_q <= last_q ? S_G0 : S_G1;
                    end else if (elig0) begin
                        state_q <= S_G0;
                    end else if (elig1) begin
                        state_q <= S_G1;
                    end
                end
                S_G0: begin
                    // A req drop wins over a coincident timeout.
                    if (!req0_i) begin
                        state_q <= S_REL;
                        last_q  <= 1'b0;
                    end else if (cs0_i || sck_chg0) begin
                        tcnt_q <= '0;
                    end else if (tmo) begin
                        timeout_err_q <= 1'b1;
                        blk0_q        <= 1'b1;
                        state_q       <= S_REL;
                        last_q        <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_G1: begin
                    if (!req1_i) begin
                        state_q <= S_REL;
                        last_q  <= 1'b1;
                    end else if (cs1_i || sck_chg1) begin
                        tcnt_q <= '0;
                    end else if (tmo) begin
                        timeout_err_q <= 1'b1;
                        blk1_q        <= 1'b1;
                        state_q       <= S_REL;
                        last_q        <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_REL: begin
                    // One guaranteed CS-high cycle between owners.
                    tcnt_q  <= '0;
                    state_q <= S_IDLE;
                end
                S_BWAIT: begin
                    if (dcnt_q == '0) begin
                        state_q <= S_BOOT;
                        boot_q  <= 1'b1;
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end
                end
                S_BOOT: begin
                    boot_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0_o        = (state_q == S_G0);
    assign gnt1_o        = (state_q == S_G1);
    assign timeout_err_o = timeout_err_q;
    assign boot_o        = boot_q;

    // Pin mux: the owner drives the pins only while it still requests, so a
    // req drop raises CS in the same cycle. Reset forces IDLE, hence CS high.
    always_comb begin
        spi_cs_o   = 1'b1;
        spi_sck_o  = 1'b0;
        spi_mosi_o = 1'b0;
        if (state_q == S_G0 && req0_i) begin
            spi_cs_o   = cs0_i;
            spi_sck_o  = sck0_i;
            spi_mosi_o = mosi0_i;
        end else if (state_q == S_G1 && req1_i) begin
            spi_cs_o   = cs1_i;
            spi_sck_o  = sck1_i;
            spi_mosi_o = mosi1_i;
        end
    end

endmodule
